// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage feeding the IF/ID latch.
//   Keeps the fetch pc, issues icache reads, and handles stalls, taken
//   branch/jump redirects (including redirects that arrive while an icache
//   miss is still outstanding) and halt.
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   ihit, imemload            icache hit and returned instruction word
//   dhit                      dcache hit, passed through to the IF/ID latch
//   stall                     hazard unit holds fetch
//   redirect, redirect_pc     taken control transfer and its target
//   halt                      halt observed downstream
//   imemREN, imemaddr         icache read request and address
//   fd_instr, fd_pc, fd_pcplusfour, fd_ihit, fd_dhit   IF/ID latch inputs
// Build option IFETCH_PERF_EN adds saturating counters perf_fetched and
// perf_wait (frozen once halted).
module ifetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        dhit,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pcplusfour,
  output logic        fd_ihit,
  output logic        fd_dhit
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc, pc_next;
  logic [XLEN-1:0]   target, target_next;
  logic [XLEN-1:0]   pc_plus4;

  assign pc_plus4 = pc + XLEN'(4);

  // State, pc and saved redirect target registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= FETCH;
      pc     <= PC_INIT;
      target <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      target <= target_next;
    end
  end

  // Next-state and outputs; halt > redirect > stall > advance
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    target_next   = target;
    imemREN       = 1'b1;
    imemaddr      = pc;
    fd_ihit       = 1'b0;
    fd_instr      = imemload;
    fd_pc         = pc;
    fd_pcplusfour = pc_plus4;
    fd_dhit       = dhit;

    case (state)
      FETCH: begin
        if (halt) begin
          state_next = HALTED;
        end else if (redirect) begin
          if (ihit) begin
            pc_next = redirect_pc;
          end else begin
            // outstanding miss cannot be cancelled; park the target
            target_next = redirect_pc;
            state_next  = DRAIN;
          end
        end else if (!stall && ihit) begin
          fd_ihit = nRST;
          pc_next = pc_plus4;
        end
      end
      DRAIN: begin
        if (halt) begin
          state_next = HALTED;
        end else begin
          if (redirect) begin
            target_next = redirect_pc;
          end
          // miss response is wrong-path; consume it and jump
          if (ihit) begin
            pc_next    = redirect ? redirect_pc : target;
            state_next = FETCH;
          end
        end
      end
      HALTED: begin
        imemREN = 1'b0;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

`ifdef IFETCH_PERF_EN
  logic count_fetch;
  logic count_wait;

  assign count_fetch = fd_ihit;
  assign count_wait  = (state != HALTED) && !ihit;

  // Saturating performance counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_fetched <= '0;
      perf_wait    <= '0;
    end else begin
      if (count_fetch && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + XLEN'(1);
      end
      if (count_wait && (perf_wait != '1)) begin
        perf_wait <= perf_wait + XLEN'(1);
      end
    end
  end
`endif

endmodule
